// File: rtl/periph_arbiter.sv
// periph_arbiter
//   Two-master, single-peripheral arbiter. It runs one transaction at a time
//   and uses round-robin arbitration between the masters.
//   Each transaction moves through IDLE -> ADDR -> (WAIT) -> DONE.
//   A transaction ends with a one-cycle ack. If the peripheral does not
//   acknowledge within ACK_TIMEOUT WAIT cycles, err is raised with the ack.
//
// Ports
//   clk, reset                  clock, asynchronous active-low reset
//   m{0,1}_req/write/addr/wdata master request side (held until ack)
//   m{0,1}_rdata/ack/err        master response side (all registered)
//   s_read, s_write             peripheral strobes
//   s_addr, s_wdata             peripheral address / write data
//   s_rdata, s_read_acc         peripheral read data and read hit (combinational)
//   s_write_acc                 peripheral write hit, one cycle after s_write
//   grant                       one-hot current owner, 00 when idle
module periph_arbiter #(
    parameter int ACK_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_write,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_write,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_read_acc,
    input  logic        s_write_acc,
    output logic [1:0]  grant
);

    localparam int CW_MIN = $clog2(ACK_TIMEOUT + 1);
    localparam int CW     = (CW_MIN > 3) ? CW_MIN : 3;
    localparam logic [31:0] ERR_DATA = 32'hcccccccc;

    typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;      // 1: m1 was served last
    logic          wr_q, wr_d;
    logic [1:0]    grant_q, grant_d;
    logic [31:0]   s_addr_q, s_addr_d;
    logic [31:0]   s_wdata_q, s_wdata_d;
    logic          s_read_q, s_read_d;
    logic          s_write_q, s_write_d;
    logic [31:0]   m0_rdata_q, m0_rdata_d;
    logic [31:0]   m1_rdata_q, m1_rdata_d;
    logic          m0_ack_q, m0_ack_d;
    logic          m1_ack_q, m1_ack_d;
    logic          m0_err_q, m0_err_d;
    logic          m1_err_q, m1_err_d;

    // Completion request raised by the FSM, applied to the granted master below.
    logic          fin;
    logic          fin_err;
    logic [31:0]   fin_data;
    logic          pick_m1;
    logic          hit;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        wr_d       = wr_q;
        grant_d    = grant_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        s_read_d   = 1'b0;
        s_write_d  = 1'b0;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        m0_ack_d   = 1'b0;
        m1_ack_d   = 1'b0;
        m0_err_d   = 1'b0;
        m1_err_d   = 1'b0;
        fin        = 1'b0;
        fin_err    = 1'b0;
        fin_data   = s_rdata;
        // With both requesting, the master not served last wins.
        pick_m1    = m1_req && (!m0_req || !last_q);
        hit        = wr_q ? s_write_acc : s_read_acc;

        case (state_q)
            IDLE: begin
                grant_d = 2'b00;
                if (m0_req || m1_req) begin
                    wr_d      = pick_m1 ? m1_write : m0_write;
                    s_addr_d  = pick_m1 ? m1_addr  : m0_addr;
                    s_wdata_d = pick_m1 ? m1_wdata : m0_wdata;
                    grant_d   = pick_m1 ? 2'b10 : 2'b01;
                    last_d    = pick_m1;
                    s_read_d  = pick_m1 ? !m1_write : !m0_write;
                    s_write_d = pick_m1 ?  m1_write :  m0_write;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (!wr_q && s_read_acc) begin
                    fin     = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d    = '0;
                    s_read_d = !wr_q;   // reads keep strobing while waiting
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (hit) begin
                    fin     = 1'b1;
                    state_d = DONE;
                end else if (cnt_d == CW'(ACK_TIMEOUT)) begin
                    fin      = 1'b1;
                    fin_err  = 1'b1;
                    fin_data = ERR_DATA;
                    state_d  = DONE;
                end else begin
                    s_read_d = !wr_q;
                end
            end
            DONE: begin
                // grant_q stays visible for the ack cycle, drops on entry to IDLE
                grant_d = 2'b00;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (fin) begin
            if (grant_q[0]) begin
                m0_ack_d = 1'b1;
                m0_err_d = fin_err;
                if (!wr_q) m0_rdata_d = fin_data;
            end
            if (grant_q[1]) begin
                m1_ack_d = 1'b1;
                m1_err_d = fin_err;
                if (!wr_q) m1_rdata_d = fin_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_q     <= 1'b1;
            wr_q       <= 1'b0;
            grant_q    <= 2'b00;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            s_read_q   <= 1'b0;
            s_write_q  <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_err_q   <= 1'b0;
            m1_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            wr_q       <= wr_d;
            grant_q    <= grant_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            s_read_q   <= s_read_d;
            s_write_q  <= s_write_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
            m0_ack_q   <= m0_ack_d;
            m1_ack_q   <= m1_ack_d;
            m0_err_q   <= m0_err_d;
            m1_err_q   <= m1_err_d;
        end
    end

    assign grant    = grant_q;
    assign s_read   = s_read_q;
    assign s_write  = s_write_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;
    assign m0_ack   = m0_ack_q;
    assign m1_ack   = m1_ack_q;
    assign m0_err   = m0_err_q;
    assign m1_err   = m1_err_q;

endmodule

// File: tb/tb_periph_arbiter.sv
// tb_periph_arbiter
//   Drives both masters and a peripheral responder with random traffic and
//   directed scenarios. Outputs are compared each cycle against a
//   transaction-level model. The model picks a winner and computes the ack
//   cycle, err and rdata of each transaction from its latency rules.
module tb_periph_arbiter;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  mreq = 2'b00;
    logic        mwr  [2];
    logic [31:0] maddr[2];
    logic [31:0] mwd  [2];
    logic [31:0] mrd  [2];   // data the peripheral returns for this txn
    int          mhit [2];   // read hit interval offset, > T means never
    logic        mwhit[2];   // write acknowledged or not
    logic [1:0]  mhold = 2'b00;
    logic        rnd_en = 1'b0;

    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
    logic        m0_ack, m1_ack, m0_err, m1_err, s_read, s_write;
    logic [1:0]  grant;
    logic [31:0] s_rdata = '0;
    logic        s_read_acc = 1'b0;
    logic        s_write_acc = 1'b0;

    int errors = 0;
    int checks = 0;

    // model state
    int          cyc = 0;
    bit          act = 0;
    int          owner = 0;
    int          start = 0;
    int          lat = 0;
    bit          mlast = 1;
    logic        e_wr, e_whit, e_err;
    logic [31:0] e_addr, e_wd, e_rd;
    int          e_hit;
    logic [31:0] hold_rd[2];

    always #5 clk = ~clk;

    periph_arbiter #(.ACK_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset),
        .m0_req(mreq[0]), .m0_write(mwr[0]), .m0_addr(maddr[0]), .m0_wdata(mwd[0]),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(mreq[1]), .m1_write(mwr[1]), .m1_addr(maddr[1]), .m1_wdata(mwd[1]),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_read(s_read), .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_read_acc(s_read_acc), .s_write_acc(s_write_acc),
        .grant(grant)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_txn(input int i, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int hitk, input logic whit);
        mwr[i] = wr; maddr[i] = a; mwd[i] = wd; mrd[i] = rd;
        mhit[i] = hitk; mwhit[i] = whit;
    endtask

    task automatic new_txn(input int i);
        set_txn(i, 1'($urandom % 2), $urandom, $urandom, $urandom,
                $urandom_range(0, T + 1), 1'(($urandom % 3) != 0));
    endtask

    task automatic model_reset();
        act = 0; mlast = 1; hold_rd[0] = '0; hold_rd[1] = '0;
    endtask

    // One clock edge seen at transaction level.
    task automatic model_edge();
        cyc++;
        if (act && cyc == start + lat) begin
            act = 0;
        end else if (!act && mreq != 2'b00) begin
            owner  = (mreq[1] && (!mreq[0] || !mlast)) ? 1 : 0;
            mlast  = (owner == 1);
            act    = 1;
            start  = cyc;
            e_wr   = mwr[owner];  e_addr = maddr[owner]; e_wd = mwd[owner];
            e_rd   = mrd[owner];  e_hit  = mhit[owner];  e_whit = mwhit[owner];
            e_err  = e_wr ? !e_whit : (e_hit > T);
            if (e_wr) lat = e_whit ? 3 : T + 2;
            else      lat = (e_hit <= T) ? e_hit + 2 : T + 2;
        end
        if (act && cyc == start + lat - 1 && !e_wr)
            hold_rd[owner] = e_err ? 32'hcccccccc : e_rd;
    endtask

    task automatic check_and_drive();
        logic       ack_iv;
        logic [7:0] exp_ctl;
        logic       xr, xw;
        ack_iv = act && (cyc == start + lat - 1);
        xr = act && !e_wr && (cyc < start + lat - 1);
        xw = act && e_wr && (cyc == start);
        exp_ctl = {act && owner == 1, act && owner == 0,
                   ack_iv && owner == 0, ack_iv && owner == 1,
                   ack_iv && owner == 0 && e_err, ack_iv && owner == 1 && e_err,
                   xr, xw};
        chk("ctl", {56'd0, grant, m0_ack, m1_ack, m0_err, m1_err, s_read, s_write},
            {56'd0, exp_ctl});
        chk("rdata", {m0_rdata, m1_rdata}, {hold_rd[0], hold_rd[1]});
        if (xr || xw) chk("s_addr", {32'd0, s_addr}, {32'd0, e_addr});
        if (xw) chk("s_wdata", {32'd0, s_wdata}, {32'd0, e_wd});

        // peripheral responder
        if (act && !e_wr) s_read_acc = (cyc == start + e_hit);
        else              s_read_acc = 1'($urandom % 2);
        if (act && e_wr)  s_write_acc = (cyc == start + 1) && e_whit;
        else              s_write_acc = 1'($urandom % 2);
        s_rdata = (act && !e_wr && cyc == start + e_hit) ? e_rd : $urandom;

        // masters
        for (int i = 0; i < 2; i++) begin
            if (mreq[i] && ack_iv && owner == i) begin
                if (rnd_en && ($urandom % 2) == 1) new_txn(i);
                else if (!mhold[i]) mreq[i] = 1'b0;
            end else if (!mreq[i] && rnd_en && ($urandom % 4) == 0) begin
                new_txn(i);
                mreq[i] = 1'b1;
            end
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            if (reset) model_edge();
            @(negedge clk);
            check_and_drive();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {56'd0, grant, m0_ack, m1_ack, m0_err, m1_err, s_read, s_write}, 64'd0);
        chk({tag, "_bus"}, {s_addr, s_wdata}, 64'd0);
        chk({tag, "_rd"}, {m0_rdata, m1_rdata}, 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) set_txn(i, 1'b0, '0, '0, '0, 0, 1'b0);
        model_reset();
        @(negedge clk);
        chk_all_zero("reset");
        run(2);
        reset = 1'b1;
        run(2);

        // m0 read hit
        set_txn(0, 1'b0, 32'h40000004, 32'h0, 32'hfffffff0, 0, 1'b0);
        mreq[0] = 1'b1;
        run(6);
        chk("m0_read_hit_data", {32'd0, m0_rdata}, {32'd0, 32'hfffffff0});

        // m1 write hit
        set_txn(1, 1'b1, 32'h4000000c, 32'h0000005a, 32'h0, 0, 1'b1);
        mreq[1] = 1'b1;
        run(7);

        // both continuously: round-robin alternation
        set_txn(0, 1'b0, 32'h10, 32'h0, 32'h1111, 1, 1'b0);
        set_txn(1, 1'b1, 32'h20, 32'h2222, 32'h0, 0, 1'b1);
        mhold = 2'b11; mreq = 2'b11;
        run(20);
        mhold = 2'b00;
        run(8);
        mreq = 2'b00;
        run(4);

        // read timeout
        set_txn(0, 1'b0, 32'h50000000, 32'h0, 32'h12345678, T + 1, 1'b0);
        mreq[0] = 1'b1;
        run(T + 5);
        chk("m0_timeout_data", {32'd0, m0_rdata}, {32'd0, 32'hcccccccc});

        // reset pulsed while in WAIT
        set_txn(0, 1'b0, 32'h50000010, 32'h0, 32'h0, T + 1, 1'b0);
        mreq[0] = 1'b1;
        run(3);
        reset = 1'b0;
        #1;
        chk_all_zero("midrst");
        model_reset();
        mreq = 2'b00;
        run(2);
        reset = 1'b1;
        set_txn(1, 1'b1, 32'h40000020, 32'hdeadbeef, 32'h0, 0, 1'b1);
        mreq[1] = 1'b1;
        run(7);

        // m1 arrives during an m0 transaction
        set_txn(0, 1'b0, 32'h60000000, 32'h0, 32'h0badf00d, 2, 1'b0);
        mreq[0] = 1'b1;
        run(2);
        set_txn(1, 1'b0, 32'h60000004, 32'h0, 32'hfeedface, 0, 1'b0);
        mreq[1] = 1'b1;
        run(12);

        // random traffic
        rnd_en = 1'b1;
        run(3000);
        rnd_en = 1'b0;
        run(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/periph_arbiter.md
PERIPH_ARBITER -- requirements
Module: periph_arbiter

Interface
REQ-001 The block SHALL have parameter ACK_TIMEOUT, default 4, the number of WAIT cycles without acknowledge before a transaction ends in error.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port m0_req / m1_req  input  1  master requests a transaction; held high until ack.
REQ-005 The block SHALL have port m0_write / m1_write  input  1  1 = write, 0 = read; stable while req is high.
REQ-006 The block SHALL have port m0_addr / m1_addr  input  32  byte address; stable while req is high.
REQ-007 The block SHALL have port m0_wdata / m1_wdata  input  32  write data; stable while req is high.
REQ-008 The block SHALL have port m0_rdata / m1_rdata  output  32  registered read data; valid in the ack cycle.
REQ-009 The block SHALL have port m0_ack / m1_ack  output  1  one-cycle completion pulse.
REQ-010 The block SHALL have port m0_err / m1_err  output  1  timeout flag; valid with ack.
REQ-011 The block SHALL have port s_read / s_write  output  1  peripheral read/write strobes.
REQ-012 The block SHALL have port s_addr / s_wdata  output  32  peripheral address and write data.
REQ-013 The block SHALL have port s_rdata  input  32  peripheral read data, combinational from s_addr.
REQ-014 The block SHALL have port s_read_acc  input  1  combinational read decode hit.
REQ-015 The block SHALL have port s_write_acc  input  1  registered write hit, valid the cycle after s_write.
REQ-016 The block SHALL have port grant  output  2  one-hot owner: bit0 = m0, bit1 = m1; 00 when idle.

Function
REQ-017 The FSM SHALL have the states IDLE, ADDR, WAIT and DONE; one transaction SHALL be in flight at most.
REQ-018 In IDLE, the FSM SHALL sample the req inputs at each edge; with any req high it SHALL latch the winner's write, addr and wdata, set grant, and go to ADDR.
REQ-019 Arbitration SHALL be round-robin: with a single requester, that requester wins; with both, the master not served last wins.
REQ-020 The last-served register SHALL update on entry to ADDR.
REQ-021 In ADDR, the block SHALL assert s_read (read) or s_write (write) for exactly one cycle and drive s_addr/s_wdata from the latched values.
REQ-022 For a read in ADDR: if s_read_acc = 1, the block SHALL capture s_rdata and go to DONE with err = 0; otherwise it SHALL go to WAIT.
REQ-023 For a write in ADDR, the block SHALL always go to WAIT.
REQ-024 In WAIT, for a write: if s_write_acc = 1, the block SHALL go to DONE with err = 0.
REQ-025 In WAIT, for a read: the block SHALL re-assert s_read, and if s_read_acc = 1 it SHALL capture s_rdata and go to DONE with err = 0.
REQ-026 The WAIT counter SHALL be 3 bits or more, clear on entry to WAIT, and increment each WAIT cycle.
REQ-027 When the WAIT counter reaches ACK_TIMEOUT, the block SHALL go to DONE with err = 1 and rdata = 32'hcccccccc.
REQ-028 In DONE, the block SHALL pulse ack (and err) for one cycle to the granted master only, hold grant, and return to IDLE.
REQ-029 m*_rdata SHALL hold its value until the next read completion for that master.
REQ-030 Latency SHALL be: read hit ack 2 cycles after req is sampled; write hit ack 3 cycles; timeout ack ACK_TIMEOUT+2 cycles.
REQ-031 A req still high at the edge after ack SHALL be treated as a new transaction.
REQ-032 The block SHALL ignore changes to a non-granted req until IDLE.
REQ-033 The block SHALL ignore changes to the granted master's inputs after latch.
REQ-034 s_read, s_write and ack SHALL never be asserted simultaneously.

Reset
REQ-035 reset low SHALL immediately force: state IDLE; grant, s_read, s_write, acks and errs 0; s_addr, s_wdata and rdatas 0; WAIT counter 0; last-served = m1, so m0 wins the first tie.
REQ-036 Reset asserted mid-transaction SHALL abort the transaction without ack; after release, the FSM SHALL start in IDLE.

Verification
REQ-037 m0 reads 0x40000004 with s_read_acc=1 and s_rdata=0xfffffff0 -> m0_ack in the 2nd cycle after sampling, m0_rdata=0xfffffff0, err=0.
REQ-038 m1 writes 0x4000000c with data 0x5a; s_write_acc=1 the cycle after s_write -> one s_write pulse, m1_ack 3 cycles after sampling.
REQ-039 m0 and m1 request together continuously -> grants alternate m0, m1, m0, m1 after reset.
REQ-040 m0 reads 0x50000000 with s_read_acc held 0 -> m0_ack with m0_err=1 and m0_rdata=0xcccccccc after ACK_TIMEOUT+2 cycles.
REQ-041 reset pulsed low during WAIT -> all outputs 0 at once, no ack; a new m1 request after release completes normally.
REQ-042 m1 req rises during an m0 transaction -> m1 is served immediately after m0's DONE; no s_* change occurs during m0's transaction.
